stage_if: RTL

Instruction-fetch stage of the 5-stage RISC-V pipeline. Owns the program counter, fetches from instruction memory over a single-outstanding req/ack handshake, and drives the IF/ID pipeline register that the decode stage consumes. It honours the hazard unit's `stall`, takes control-flow redirects from EX, and discards stale memory responses. A one-entry skid buffer absorbs a response that arrives while decode is stalled.

---
 rtl/stage_if.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/stage_if.sv
// Instruction fetch: owns the PC, single-outstanding req/ack fetch, IF/ID register with a one-entry skid.
// One instruction per cycle at zero wait; stall holds IF/ID and parks an arriving response in the skid.
module stage_if #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_HOLD   = 2'd2,
        ST_SQUASH = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_fetch_pc;
    logic [31:0] w_fetch_pc_nxt;
    logic [31:0] r_pending_pc;
    logic [31:0] w_pending_pc_nxt;
    logic [31:0] r_skid_pc;
    logic [31:0] w_skid_pc_nxt;
    logic [31:0] r_skid_instr;
    logic [31:0] w_skid_instr_nxt;
    logic [31:0] r_if_id_pc;
    logic [31:0] w_if_id_pc_nxt;
    logic [31:0] r_if_id_instr;
    logic [31:0] w_if_id_instr_nxt;
    logic        r_if_id_valid;
    logic        w_if_id_valid_nxt;

    logic [31:0] w_target;
    logic [31:0] w_pc_inc;

    assign w_target    = redirect_pc & 32'hFFFF_FFFC;
    assign w_pc_inc    = r_fetch_pc + 32'd4;

    assign imem_req    = (r_state == ST_REQ) || (r_state == ST_SQUASH);
    assign imem_addr   = r_fetch_pc;
    assign if_id_pc    = r_if_id_pc;
    assign if_id_instr = r_if_id_instr;
    assign if_id_valid = r_if_id_valid;

    always_comb begin
        w_state_nxt       = r_state;
        w_fetch_pc_nxt    = r_fetch_pc;
        w_pending_pc_nxt  = r_pending_pc;
        w_skid_pc_nxt     = r_skid_pc;
        w_skid_instr_nxt  = r_skid_instr;
        w_if_id_pc_nxt    = r_if_id_pc;
        w_if_id_instr_nxt = r_if_id_instr;
        w_if_id_valid_nxt = r_if_id_valid;

        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_REQ;
            end

            ST_REQ: begin
                if (redirect) begin
                    w_if_id_instr_nxt = NOP_INSTR;
                    w_if_id_valid_nxt = 1'b0;
                    // Without an ack the request must stay up at the old address until it drains.
                    if (imem_ack) begin
                        w_fetch_pc_nxt = w_target;
                    end else begin
                        w_pending_pc_nxt = w_target;
                        w_state_nxt      = ST_SQUASH;
                    end
                end else if (imem_ack) begin
                    w_fetch_pc_nxt = w_pc_inc;
                    if (stall) begin
                        w_skid_pc_nxt    = r_fetch_pc;
                        w_skid_instr_nxt = imem_rdata;
                        w_state_nxt      = ST_HOLD;
                    end else begin
                        w_if_id_pc_nxt    = r_fetch_pc;
                        w_if_id_instr_nxt = imem_rdata;
                        w_if_id_valid_nxt = 1'b1;
                    end
                end else if (!stall) begin
                    w_if_id_instr_nxt = NOP_INSTR;
                    w_if_id_valid_nxt = 1'b0;
                end
            end

            ST_HOLD: begin
                if (redirect) begin
                    w_if_id_instr_nxt = NOP_INSTR;
                    w_if_id_valid_nxt = 1'b0;
                    w_fetch_pc_nxt    = w_target;
                    w_state_nxt       = ST_REQ;
                end else if (!stall) begin
                    w_if_id_pc_nxt    = r_skid_pc;
                    w_if_id_instr_nxt = r_skid_instr;
                    w_if_id_valid_nxt = 1'b1;
                    w_state_nxt       = ST_REQ;
                end
            end

            ST_SQUASH: begin
                if (redirect) begin
                    w_if_id_instr_nxt = NOP_INSTR;
                    w_if_id_valid_nxt = 1'b0;
                    // Newest target wins, even when the stale ack lands on the same edge.
                    if (imem_ack) begin
                        w_fetch_pc_nxt = w_target;
                        w_state_nxt    = ST_REQ;
                    end else begin
                        w_pending_pc_nxt = w_target;
                    end
                end else if (imem_ack) begin
                    w_fetch_pc_nxt = r_pending_pc;
                    w_state_nxt    = ST_REQ;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_fetch_pc    <= RESET_PC;
            r_pending_pc  <= RESET_PC;
            r_skid_pc     <= 32'd0;
            r_skid_instr  <= NOP_INSTR;
            r_if_id_pc    <= 32'd0;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_fetch_pc    <= w_fetch_pc_nxt;
            r_pending_pc  <= w_pending_pc_nxt;
            r_skid_pc     <= w_skid_pc_nxt;
            r_skid_instr  <= w_skid_instr_nxt;
            r_if_id_pc    <= w_if_id_pc_nxt;
            r_if_id_instr <= w_if_id_instr_nxt;
            r_if_id_valid <= w_if_id_valid_nxt;
        end
    end

    // An unacked request must keep its address until the memory answers.
    a_addr_stable: assert property (
        @(posedge clk) disable iff (reset)
        (imem_req && !imem_ack) |=> (imem_req && $stable(imem_addr))
    );

endmodule
